// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use hazard detection, freeze/flush handling
// and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val1,
    input  logic [DATA_W-1:0]     id_val2,
    input  logic [DATA_W-1:0]     id_st_val,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [3:0]            id_exe_cmd,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_wb_en,
    input  logic [1:0]            id_branch_type,
    input  logic                  id_is_immediate,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val1,
    output logic [DATA_W-1:0]     ex_val2,
    output logic [DATA_W-1:0]     ex_st_val,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [3:0]            ex_exe_cmd,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_wb_en,
    output logic [1:0]            ex_branch_type,
    output logic                  ex_is_immediate,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      bubble_count
);

    logic src2_used;
    logic load_bubble;
    logic count_bubble;

    // Stores and BNE read src2 even when operand B is an immediate.
    always_comb begin
        src2_used    = !id_is_immediate || id_mem_write || (id_branch_type == 2'b10);
        hazard_stall = id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                       ((id_src1 == ex_dest) || (src2_used && (id_src2 == ex_dest)));
        load_bubble  = flush || hazard_stall;
        count_bubble = flush ? id_valid : hazard_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid        <= 1'b0;
            ex_pc           <= '0;
            ex_val1         <= '0;
            ex_val2         <= '0;
            ex_st_val       <= '0;
            ex_src1         <= '0;
            ex_src2         <= '0;
            ex_dest         <= '0;
            ex_exe_cmd      <= '0;
            ex_mem_read     <= 1'b0;
            ex_mem_write    <= 1'b0;
            ex_wb_en        <= 1'b0;
            ex_branch_type  <= '0;
            ex_is_immediate <= 1'b0;
            bubble_count    <= '0;
        end else if (!freeze) begin
            if (load_bubble) begin
                ex_valid        <= 1'b0;
                ex_pc           <= '0;
                ex_val1         <= '0;
                ex_val2         <= '0;
                ex_st_val       <= '0;
                ex_src1         <= '0;
                ex_src2         <= '0;
                ex_dest         <= '0;
                ex_exe_cmd      <= '0;
                ex_mem_read     <= 1'b0;
                ex_mem_write    <= 1'b0;
                ex_wb_en        <= 1'b0;
                ex_branch_type  <= '0;
                ex_is_immediate <= 1'b0;
            end else begin
                ex_valid        <= id_valid;
                ex_pc           <= id_pc;
                ex_val1         <= id_val1;
                ex_val2         <= id_val2;
                ex_st_val       <= id_st_val;
                ex_src1         <= id_src1;
                ex_src2         <= id_src2;
                ex_dest         <= id_dest;
                ex_exe_cmd      <= id_exe_cmd;
                ex_mem_read     <= id_mem_read;
                ex_mem_write    <= id_mem_write;
                ex_wb_en        <= id_wb_en;
                ex_branch_type  <= id_branch_type;
                ex_is_immediate <= id_is_immediate;
            end
            if (count_bubble && (bubble_count != '1)) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

endmodule
